// File: rtl/cfar_detector.sv
// -----------------------------------------------------------------------------
// cfar_detector
//   Per-sweep threshold detector that feeds the CFAR threshold loop. A trigger
//   in IDLE starts a sweep and latches the threshold (door). The first DELAY
//   valid samples are skipped. The next WINDOW valid samples are compared
//   against the latched door, and an M-of-N integration filter over the raw
//   compares produces one detection bit per sample. At the end of the sweep
//   the number of detections is published and an end-of-sweep tick is pulsed.
//
// Ports
//   i_clk          system clock
//   i_reset        synchronous active-high reset
//   i_trig         sweep trigger, level sampled every clock
//   i_sample       sample magnitude, unsigned, DW bits
//   i_sample_valid sample qualifier
//   i_door         threshold from the CFAR adapter, unsigned 16 bits
//   o_start        1-clk strobe: sweep accepted
//   o_bits         filtered detection for the last window sample
//   o_bits_valid   1-clk qualifier for o_bits
//   o_pulse_tick   1-clk strobe: sweep complete
//   o_hit_count    number of detections in the last completed sweep
//   o_busy         high while a sweep is in progress (not IDLE)
//   o_trig_miss    1-clk strobe: trigger seen while busy and ignored
// -----------------------------------------------------------------------------
module cfar_detector #(
    parameter int unsigned DW     = 16,
    parameter int unsigned DELAY  = 40,
    parameter int unsigned WINDOW = 200,
    parameter int unsigned M      = 3,
    parameter int unsigned N      = 5
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_trig,
    input  logic [DW-1:0] i_sample,
    input  logic          i_sample_valid,
    input  logic [15:0]   i_door,
    output logic          o_start,
    output logic          o_bits,
    output logic          o_bits_valid,
    output logic          o_pulse_tick,
    output logic [15:0]   o_hit_count,
    output logic          o_busy,
    output logic          o_trig_miss
);

    localparam int unsigned MaxCnt = (DELAY > WINDOW) ? DELAY : WINDOW;
    localparam int unsigned CW     = $clog2(MaxCnt) + 1;
    // Compare width wide enough for both the sample and the 16-bit door.
    localparam int unsigned KW     = (DW > 16) ? DW : 16;

    typedef enum logic [1:0] {
        StIdle,
        StDly,
        StWin,
        StDone
    } state_e;

    state_e        r_state, w_state_d;
    logic [CW-1:0] r_cnt, w_cnt_d;
    logic [N-1:0]  r_hist, w_hist_d;
    logic [15:0]   r_run, w_run_d;
    logic [15:0]   r_door, w_door_d;

    logic          r_start, w_start_d;
    logic          r_bits, w_bits_d;
    logic          r_bits_valid, w_bits_valid_d;
    logic          r_tick, w_tick_d;
    logic [15:0]   r_hit, w_hit_d;
    logic          r_busy, w_busy_d;
    logic          r_miss, w_miss_d;

    logic          w_raw;
    logic [N-1:0]  w_hist_new;
    logic [3:0]    w_pop;
    logic          w_bit;

    // Raw compare is strict: a sample equal to the door is not a hit.
    assign w_raw      = (KW'(i_sample) > KW'(r_door));
    // Newest compare enters at bit 0, oldest falls off the top.
    assign w_hist_new = N'({r_hist, w_raw});

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_pop = w_pop + 4'(w_hist_new[i]);
        end
    end

    assign w_bit = (w_pop >= 4'(M));

    always_comb begin
        w_state_d      = r_state;
        w_cnt_d        = r_cnt;
        w_hist_d       = r_hist;
        w_run_d        = r_run;
        w_door_d       = r_door;
        w_start_d      = 1'b0;
        w_bits_d       = r_bits;
        w_bits_valid_d = 1'b0;
        w_tick_d       = 1'b0;
        w_hit_d        = r_hit;
        w_miss_d       = i_trig && (r_state != StIdle);

        case (r_state)
            StIdle: begin
                if (i_trig) begin
                    w_state_d = StDly;
                    w_start_d = 1'b1;
                    w_door_d  = i_door;
                    w_cnt_d   = '0;
                    w_hist_d  = '0;
                    w_run_d   = '0;
                end
            end
            StDly: begin
                if (i_sample_valid) begin
                    // The DELAY-th valid sample is consumed here and never compared.
                    if (r_cnt == CW'(DELAY - 1)) begin
                        w_state_d = StWin;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            StWin: begin
                if (i_sample_valid) begin
                    w_hist_d       = w_hist_new;
                    w_bits_d       = w_bit;
                    w_bits_valid_d = 1'b1;
                    if (w_bit && (r_run != 16'hFFFF)) begin
                        w_run_d = r_run + 16'd1;
                    end
                    if (r_cnt == CW'(WINDOW - 1)) begin
                        w_state_d = StDone;
                        w_cnt_d   = '0;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
            end
            StDone: begin
                w_hit_d   = r_run;
                w_tick_d  = 1'b1;
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Registered from next state so o_busy tracks the state register exactly.
        w_busy_d = (w_state_d != StIdle);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_hist       <= '0;
            r_run        <= '0;
            r_door       <= '0;
            r_start      <= 1'b0;
            r_bits       <= 1'b0;
            r_bits_valid <= 1'b0;
            r_tick       <= 1'b0;
            r_hit        <= '0;
            r_busy       <= 1'b0;
            r_miss       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_hist       <= w_hist_d;
            r_run        <= w_run_d;
            r_door       <= w_door_d;
            r_start      <= w_start_d;
            r_bits       <= w_bits_d;
            r_bits_valid <= w_bits_valid_d;
            r_tick       <= w_tick_d;
            r_hit        <= w_hit_d;
            r_busy       <= w_busy_d;
            r_miss       <= w_miss_d;
        end
    end

    assign o_start      = r_start;
    assign o_bits       = r_bits;
    assign o_bits_valid = r_bits_valid;
    assign o_pulse_tick = r_tick;
    assign o_hit_count  = r_hit;
    assign o_busy       = r_busy;
    assign o_trig_miss  = r_miss;

endmodule

// File: tb/tb_cfar_detector.sv
// -----------------------------------------------------------------------------
// tb_cfar_detector
//   Self-checking bench for cfar_detector. A small instance (DELAY=4, WINDOW=8,
//   M=2, N=3) covers the directed and randomized sweeps; a default-parameter
//   instance covers the full-length sweep. Expected detections come from a
//   sliding M-of-N count over the window samples.
// -----------------------------------------------------------------------------
module tb_cfar_detector;

    logic        clk = 1'b0;
    logic        reset;
    logic        trig;
    logic        valid;
    logic [15:0] sample;
    logic [15:0] door;

    always #5 clk = ~clk;

    logic        s_start, s_bits, s_bits_valid, s_tick, s_busy, s_miss;
    logic [15:0] s_hit;
    logic        d_start, d_bits, d_bits_valid, d_tick, d_busy, d_miss;
    logic [15:0] d_hit;

    cfar_detector #(
        .DW(16), .DELAY(4), .WINDOW(8), .M(2), .N(3)
    ) u_dut_small (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_trig         (trig),
        .i_sample       (sample),
        .i_sample_valid (valid),
        .i_door         (door),
        .o_start        (s_start),
        .o_bits         (s_bits),
        .o_bits_valid   (s_bits_valid),
        .o_pulse_tick   (s_tick),
        .o_hit_count    (s_hit),
        .o_busy         (s_busy),
        .o_trig_miss    (s_miss)
    );

    cfar_detector u_dut_dflt (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_trig         (trig),
        .i_sample       (sample),
        .i_sample_valid (valid),
        .i_door         (door),
        .o_start        (d_start),
        .o_bits         (d_bits),
        .o_bits_valid   (d_bits_valid),
        .o_pulse_tick   (d_tick),
        .o_hit_count    (d_hit),
        .o_busy         (d_busy),
        .o_trig_miss    (d_miss)
    );

    // Output selection: 0 = small instance, 1 = default instance.
    int          sel = 0;
    logic        m_start, m_bits, m_bits_valid, m_tick, m_busy, m_miss;
    logic [15:0] m_hit;

    assign m_start      = (sel != 0) ? d_start      : s_start;
    assign m_bits       = (sel != 0) ? d_bits       : s_bits;
    assign m_bits_valid = (sel != 0) ? d_bits_valid : s_bits_valid;
    assign m_tick       = (sel != 0) ? d_tick       : s_tick;
    assign m_busy       = (sel != 0) ? d_busy       : s_busy;
    assign m_miss       = (sel != 0) ? d_miss       : s_miss;
    assign m_hit        = (sel != 0) ? d_hit        : s_hit;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: outputs sampled on the falling edge; only ever appended/incremented.
    int got_bits[$];
    int got_cyc[$];
    int n_start = 0;
    int n_tick  = 0;
    int n_miss  = 0;

    always @(negedge clk) begin
        if (m_bits_valid) begin
            got_bits.push_back(int'(m_bits));
            got_cyc.push_back(cyc);
        end
        if (m_start) n_start <= n_start + 1;
        if (m_tick)  n_tick  <= n_tick + 1;
        if (m_miss)  n_miss  <= n_miss + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_start"}, 32'(m_start), 0);
        check_eq({tag, "_bits"},  32'(m_bits), 0);
        check_eq({tag, "_bv"},    32'(m_bits_valid), 0);
        check_eq({tag, "_tick"},  32'(m_tick), 0);
        check_eq({tag, "_hit"},   32'(m_hit), 0);
        check_eq({tag, "_busy"},  32'(m_busy), 0);
        check_eq({tag, "_miss"},  32'(m_miss), 0);
    endtask

    // Window samples of the current sweep, in arrival order.
    int win_s[$];
    int exp_cyc[$];

    // Detection k: at least m of the raw compares k-n+1..k (within this sweep) exceed door.
    function automatic int model_bit(int k, int dr, int m, int n);
        int cnt = 0;
        for (int j = k - n + 1; j <= k; j++) begin
            if (j >= 0 && win_s[j] > dr) cnt++;
        end
        return (cnt >= m) ? 1 : 0;
    endfunction

    task automatic idle_gap(input int lo, input int hi);
        int g = $urandom_range(hi, lo);
        repeat (g) begin
            @(posedge clk); #1;
            valid  = 1'b0;
            trig   = 1'b0;
            sample = 16'($urandom);
        end
    endtask

    task automatic put_sample(input int v);
        @(posedge clk); #1;
        valid  = 1'b1;
        trig   = 1'b0;
        sample = 16'(v);
    endtask

    // One sweep. miss_at: window index at which trig is pulsed and door forced to 0.
    // abort_at: window index at which reset is pulsed instead of a sample.
    task automatic run_sweep(input int delay, input int dr, input int m, input int n,
                             input int glo, input int ghi, input int miss_at,
                             input int abort_at, input string tag);
        int b0  = got_bits.size();
        int st0 = n_start;
        int tk0 = n_tick;
        int ms0 = n_miss;
        int t   = 0;
        int hit = 0;
        int nb;
        exp_cyc.delete();

        @(posedge clk); #1;
        trig  = 1'b1;
        door  = 16'(dr);
        valid = 1'b0;
        @(posedge clk); #1;
        trig = 1'b0;
        check_eq({tag, "_start"}, 32'(m_start), 1);
        check_eq({tag, "_busy"},  32'(m_busy), 1);

        for (int i = 0; i < delay; i++) begin
            idle_gap(glo, ghi);
            put_sample(int'($urandom_range(65535, 0)));
        end

        for (int i = 0; i < win_s.size(); i++) begin
            idle_gap(glo, ghi);
            if (i == abort_at) begin
                @(posedge clk); #1;
                valid = 1'b0;
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                check_zero({tag, "_rst"});
                return;
            end
            put_sample(win_s[i]);
            exp_cyc.push_back(cyc + 1);
            if (i == miss_at) begin
                trig = 1'b1;
                door = 16'd0;
            end
        end
        @(posedge clk); #1;
        valid = 1'b0;
        trig  = 1'b0;

        while (n_tick == tk0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq({tag, "_tick_seen"}, 32'(n_tick - tk0), 1);

        nb = got_bits.size() - b0;
        check_eq({tag, "_nbits"}, 32'(nb), 32'(win_s.size()));
        for (int k = 0; k < win_s.size(); k++) begin
            int eb = model_bit(k, dr, m, n);
            hit += eb;
            if (k < nb) begin
                check_eq($sformatf("%s_bit%0d", tag, k), 32'(got_bits[b0 + k]), 32'(eb));
                check_eq($sformatf("%s_lat%0d", tag, k), 32'(got_cyc[b0 + k]),
                         32'(exp_cyc[k]));
            end
        end
        if (hit > 65535) hit = 65535;
        check_eq({tag, "_hit"},    32'(m_hit), 32'(hit));
        check_eq({tag, "_nstart"}, 32'(n_start - st0), 1);
        check_eq({tag, "_nmiss"},  32'(n_miss - ms0), (miss_at >= 0) ? 1 : 0);
        check_eq({tag, "_idle"},   32'(m_busy), 0);
    endtask

    task automatic load_t1();
        win_s.delete();
        win_s = '{50, 150, 150, 50, 50, 150, 50, 150};
    endtask

    initial begin
        int dr;
        reset  = 1'b1;
        trig   = 1'b0;
        valid  = 1'b0;
        sample = '0;
        door   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sel = 0;
        #1;
        check_zero("rst_small");
        sel = 1;
        #1;
        check_zero("rst_dflt");
        sel = 0;

        // Directed: basic window
        load_t1();
        run_sweep(4, 100, 2, 3, 0, 0, -1, -1, "t1");
        check_eq("t1_hit_const", 32'(s_hit), 3);

        // Equal to door never hits; one above always does
        win_s.delete();
        repeat (8) win_s.push_back(100);
        run_sweep(4, 100, 2, 3, 0, 1, -1, -1, "t2a");
        win_s.delete();
        repeat (8) win_s.push_back(101);
        run_sweep(4, 100, 2, 3, 0, 1, -1, -1, "t2b");
        check_eq("t2b_hit_const", 32'(s_hit), 7);

        // Gaps of 3 idle clocks between samples
        load_t1();
        run_sweep(4, 100, 2, 3, 3, 3, -1, -1, "t3");

        // Trig and door change mid-window are ignored
        load_t1();
        run_sweep(4, 100, 2, 3, 0, 2, 3, -1, "t4");
        check_eq("t4_hit_const", 32'(s_hit), 3);

        // Reset mid-window, then a clean repeat
        load_t1();
        run_sweep(4, 100, 2, 3, 0, 1, -1, 4, "t5a");
        load_t1();
        run_sweep(4, 100, 2, 3, 0, 0, -1, -1, "t5b");

        // Randomized sweeps around the door
        for (int r = 0; r < 8; r++) begin
            dr = int'($urandom_range(60000, 1000));
            win_s.delete();
            for (int i = 0; i < 8; i++) begin
                win_s.push_back(dr - 3 + int'($urandom_range(6, 0)));
            end
            run_sweep(4, dr, 2, 3, 0, 2, ((r % 3) == 0) ? int'($urandom_range(7, 0)) : -1,
                      -1, $sformatf("rnd%0d", r));
        end

        // Default parameters: full-length sweep, every sample above door
        sel = 1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_zero("t6_rst");
        dr = 1000;
        win_s.delete();
        for (int i = 0; i < 200; i++) begin
            win_s.push_back(int'($urandom_range(65535, 1001)));
        end
        run_sweep(40, dr, 3, 5, 0, 1, -1, -1, "t6");
        check_eq("t6_hit_const", 32'(d_hit), 198);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
